// File: rtl/timer_arb_pkg.sv
// Shared types, defaults and the round-robin search used by the interval timer arbiter.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_R = 4;

  // Upper bound on requesters the search function handles; R must not exceed it.
  localparam int RMAX   = 32;
  localparam int RMAX_W = 5;

  // First set bit of req at or above ptr, wrapping past r-1 back to 0.
  // Returns ptr when req is empty; callers only use the result when req != 0.
  function automatic int unsigned rr_pick(input logic [RMAX-1:0] req,
                                          input int unsigned     ptr,
                                          input int unsigned     r);
    int unsigned idx;
    int unsigned result;
    logic        found;
    result = ptr;
    found  = 1'b0;
    for (int unsigned k = 0; k < RMAX; k++) begin
      if (k < r && !found) begin
        idx = ptr + k;
        if (idx >= r) begin
          idx = idx - r;
        end
        if (req[idx[RMAX_W-1:0]]) begin
          found  = 1'b1;
          result = idx;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/interval_timer_arbiter_if.sv
// Request/grant bundle between the requesting control FSMs and the shared interval timer.
interface interval_timer_arbiter_if #(
  parameter int N = timer_arb_pkg::DEFAULT_N,
  parameter int R = timer_arb_pkg::DEFAULT_R
) ();

  logic [R-1:0]   req;
  logic [R*N-1:0] len;
  logic [R-1:0]   grant;
  logic [R-1:0]   done;
  logic           busy;
  logic [N-1:0]   count;

  modport master (
    output req,
    output len,
    input  grant,
    input  done,
    input  busy,
    input  count
  );

  modport slave (
    input  req,
    input  len,
    output grant,
    output done,
    output busy,
    output count
  );

endinterface

// File: rtl/interval_counter.sv
// N-bit up counter with synchronous clear/enable and a match flag against a loaded target.
module interval_counter
  import timer_arb_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [N-1:0] target,
  output logic [N-1:0] count,
  output logic         match
);

  logic [N-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign match = (count_reg == target);

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter that lends one shared interval counter to R requesters in turn.
module interval_timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int R = DEFAULT_R
) (
  input  logic                     clk,
  input  logic                     reset,
  interval_timer_arbiter_if.slave  bus
);

  localparam int W = (R > 1) ? $clog2(R) : 1;

  state_t         state_reg, state_next;
  logic [R-1:0]   grant_reg, grant_next;
  logic [R-1:0]   done_reg, done_next;
  logic [W-1:0]   ptr_reg, ptr_next;
  logic [W-1:0]   winner_reg, winner_next;
  logic [N-1:0]   target_reg, target_next;
  logic           busy_reg;

  logic [W-1:0]   pick;
  logic [W-1:0]   ptr_after;
  logic [R-1:0]   pick_onehot;
  logic [R-1:0]   winner_onehot;
  logic           cnt_clear;
  logic           cnt_enable;
  logic           cnt_match;
  logic [N-1:0]   cnt_count;

  interval_counter #(
    .N (N)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .target (target_reg),
    .count  (cnt_count),
    .match  (cnt_match)
  );

  assign pick = W'(rr_pick(RMAX'(bus.req), 32'(ptr_reg), R));

  // Pointer always advances past the requester just served, whether it finished or aborted.
  assign ptr_after = (winner_reg == W'(R - 1)) ? '0 : winner_reg + 1'b1;

  for (genvar gi = 0; gi < R; gi++) begin : g_onehot
    assign pick_onehot[gi]   = (pick == W'(gi));
    assign winner_onehot[gi] = (winner_reg == W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      done_reg   <= '0;
      ptr_reg    <= '0;
      winner_reg <= '0;
      target_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      ptr_reg    <= ptr_next;
      winner_reg <= winner_next;
      target_reg <= target_next;
      busy_reg   <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    done_next   = '0;
    ptr_next    = ptr_reg;
    winner_next = winner_reg;
    target_next = target_reg;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          winner_next = pick;
          target_next = bus.len[pick*N +: N];
          grant_next  = pick_onehot;
          cnt_clear   = 1'b1;
          state_next  = RUN;
        end
      end

      RUN: begin
        // A dropped request wins over a same-cycle target match: no done pulse.
        if (!bus.req[winner_reg]) begin
          grant_next = '0;
          cnt_clear  = 1'b1;
          ptr_next   = ptr_after;
          state_next = IDLE;
        end else if (cnt_match) begin
          grant_next = '0;
          done_next  = winner_onehot;
          cnt_clear  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      DONE: begin
        cnt_clear  = 1'b1;
        ptr_next   = ptr_after;
        state_next = IDLE;
      end

      default: begin
        grant_next = '0;
        cnt_clear  = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.grant = grant_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = busy_reg;
  assign bus.count = cnt_count;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Self-checking bench: vector table plus scoreboard of expected grants, with hand-written corner sequences.
module tb_interval_timer_arbiter;

  localparam int N = 8;
  localparam int R = 4;
  localparam int WAIT_MAX = 1000;

  logic clk;
  logic reset;
  int   cyc;

  interval_timer_arbiter_if #(.N(N), .R(R)) bus ();

  interval_timer_arbiter #(.N(N), .R(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_len;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  logic mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    checks++;
    if (act === req_val) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, req_val);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: no event within %0d cycles, event required", name, WAIT_MAX);
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (bus.grant != '0) return;
    end
    timeout(name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (bus.done != '0) return;
    end
    timeout(name);
  endtask

  task automatic wait_count(input string name, input logic [7:0] v);
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      if (bus.count == v) return;
    end
    timeout(name);
  endtask

  // Scoreboard monitor: tracks each grant window and compares it when the window closes.
  logic       in_grant = 1'b0;
  logic [3:0] seen_grant;
  int         hold;
  logic       seq_ok;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.grant != '0) begin
        if (!in_grant) begin
          in_grant   = 1'b1;
          hold       = 0;
          seen_grant = bus.grant;
          seq_ok     = 1'b1;
        end
        if (bus.grant != seen_grant || bus.count != 8'(hold) || !bus.busy || bus.done != '0)
          seq_ok = 1'b0;
        hold++;
      end else if (in_grant) begin
        in_grant = 1'b0;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_grant", 32'(seen_grant), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("txn grant=%b hold=%0d done=%b (exp grant=%b len=%0d)",
                   seen_grant, hold, bus.done, e.grant, e.len);
          check("sb_grant", 32'(seen_grant), 32'(e.grant));
          check("sb_hold", 32'(hold), 32'(int'(e.len) + 1));
          check("sb_done", 32'(bus.done), 32'(e.grant));
          check("sb_count_seq", 32'(seq_ok), 32'd1);
          check("sb_done_cycle", {bus.busy, 23'd0, bus.count}, {1'b1, 31'd0});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, completion required");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];
  int   starts[5];

  initial begin
    vecs[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0001, 8'd3};
    vecs[1] = '{4'b0011, {8'd0, 8'd0, 8'd5, 8'd2}, 4'b0010, 8'd5};
    vecs[2] = '{4'b0011, {8'd0, 8'd0, 8'd5, 8'd1}, 4'b0001, 8'd1};
    vecs[3] = '{4'b1000, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b1000, 8'd0};
    vecs[4] = '{4'b1010, {8'd7, 8'd0, 8'd4, 8'd0}, 4'b0010, 8'd4};
    vecs[5] = '{4'b0110, {8'd0, 8'd6, 8'd9, 8'd0}, 4'b0100, 8'd6};
    vecs[6] = '{4'b0101, {8'd0, 8'd3, 8'd0, 8'd2}, 4'b0001, 8'd2};
    vecs[7] = '{4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, 4'b0010, 8'd3};

    cyc     = 0;
    reset   = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.grant, bus.done, 7'd0, bus.busy, 8'd0, bus.count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_req", {bus.grant, bus.done, 7'd0, bus.busy, 8'd0, bus.count}, 32'd0);

    // Round-robin fairness: everyone requesting, all zero-length intervals.
    for (int i = 0; i < 5; i++) exp_q.push_back('{4'(1 << (i % 4)), 8'd0});
    bus.req = 4'b1111;
    bus.len = '0;
    for (int i = 0; i < 5; i++) begin
      wait_grant("rr_grant");
      starts[i] = cyc;
      if (i > 0) check("rr_period", 32'(starts[i] - starts[i-1]), 32'd3);
      wait_done("rr_done");
    end
    bus.req = '0;
    @(negedge clk);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      bus.req = vecs[i].req;
      bus.len = vecs[i].len;
      exp_q.push_back('{vecs[i].exp_grant, vecs[i].exp_len});
      @(negedge clk);
      check("vec_latency", 32'(bus.grant), 32'(vecs[i].exp_grant));
      wait_done("vec_done");
      bus.req = '0;
      @(negedge clk);
      check("vec_idle", {bus.grant, bus.done, 7'd0, bus.busy, 8'd0, bus.count}, 32'd0);
    end

    // Abort: requester 2 drops its request at count 4.
    mon_en  = 1'b0;
    bus.req = 4'b0100;
    bus.len = {8'd0, 8'd10, 8'd0, 8'd0};
    wait_grant("abort_grant_wait");
    check("abort_grant", 32'(bus.grant), 32'b0100);
    wait_count("abort_count_wait", 8'd4);
    bus.req = '0;
    @(negedge clk);
    check("abort_grant_clr", 32'(bus.grant), 32'd0);
    check("abort_count_clr", 32'(bus.count), 32'd0);
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("abort_no_done2", 32'(bus.done), 32'd0);
    bus.req = 4'b1001;
    bus.len = {8'd50, 8'd0, 8'd0, 8'd0};
    @(negedge clk);
    check("abort_next_owner", 32'(bus.grant), 32'b1000);
    bus.req = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Full range with a mid-run len change that must be ignored.
    exp_q.push_back('{4'b0010, 8'd255});
    bus.req = 4'b0010;
    bus.len = {8'd0, 8'd0, 8'd255, 8'd0};
    wait_grant("full_grant_wait");
    repeat (3) @(negedge clk);
    bus.len = {8'd0, 8'd0, 8'd5, 8'd0};
    wait_done("full_done_wait");
    check("full_done", 32'(bus.done), 32'b0010);
    bus.req = '0;
    @(negedge clk);
    check("full_idle", {bus.grant, bus.done, 7'd0, bus.busy, 8'd0, bus.count}, 32'd0);

    // Leave the pointer at 1 so a pointer that survives reset would pick index 1 below.
    exp_q.push_back('{4'b0001, 8'd1});
    bus.req = 4'b0001;
    bus.len = {8'd0, 8'd0, 8'd0, 8'd1};
    wait_done("pre_rst_done");
    bus.req = '0;
    @(negedge clk);

    // Reset in the middle of a run.
    mon_en  = 1'b0;
    bus.req = 4'b0100;
    bus.len = {8'd0, 8'd20, 8'd0, 8'd0};
    wait_grant("rst_grant_wait");
    wait_count("rst_count_wait", 8'd7);
    reset = 1'b1;
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    reset   = 1'b0;
    bus.req = 4'b0011;
    bus.len = {8'd0, 8'd0, 8'd2, 8'd2};
    @(negedge clk);
    check("rst_ptr_winner", 32'(bus.grant), 32'b0001);
    bus.req = '0;
    repeat (2) @(negedge clk);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/interval_timer_arbiter.md
# interval_timer_arbiter

Shares one N-bit interval counter between R requesters that each need a programmable wait, for example pixel-pipeline settle delays, key-refresh holdoffs or packet pacing in the FPGA video path. A round-robin arbiter grants the counter to one requester at a time, latches that requester's interval, and runs the counter to the interval. It then returns a one-cycle done pulse to the winner and rearbitrates. The block sits between the requesting control FSMs and the shared counter resource.

## Interface
- N, default 8: counter/interval width in bits.
- R, default 4: number of requesters, with R ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req  input  R  per-requester request level; held until done or abort.
- len  input  R*N  flattened intervals; requester i uses bits [i*N +: N]; sampled only at grant.
- grant  output  R  one-hot owner of the counter; all-zero when unowned.
- done  output  R  one-cycle pulse to the owner when its interval completes.
- busy  output  1  high whenever state ≠ IDLE.
- count  output  N  current counter value; 0 outside RUN.

## Operation
- States:
  - IDLE: no owner.
  - RUN: counter owned and counting.
  - DONE: completion pulse cycle.
- IDLE:
  - If req ≠ 0, pick the winner as the first set bit searching upward from ptr, wrapping past R−1 to 0.
  - Latch target = len[winner], clear count to 0, set grant = one-hot(winner), go to RUN.
  - If req = 0, stay in IDLE.
- RUN, count = target: go to DONE (takes precedence over the increment).
- RUN, req[winner] = 0 (abort):
  - Clear grant, count ← 0, go to IDLE.
  - No done pulse; ptr ← winner+1 mod R.
  - Abort takes priority over target match in the same cycle.
- RUN, otherwise: count ← count+1.
- DONE:
  - done[winner] = 1, grant = 0, count ← 0, ptr ← winner+1 mod R.
  - Next state is IDLE.
- Width rules:
  - The counter never wraps; target ≤ 2^N−1, so the match always occurs first.
  - target = 2^N−1 runs the full range.
- len changes after grant have no effect. req from non-owners is ignored until IDLE.
- Reset (any state, including mid-RUN):
  - state = IDLE, ptr = 0.
  - grant = 0, done = 0, busy = 0, count = 0.
  - No done pulse is emitted for an interrupted interval.

## Timing
- req seen in IDLE at cycle k → grant asserted from cycle k+1.
- Grant is held L+1 cycles for interval L; count shows 0..L during those cycles.
- done pulses at cycle k+L+2, with grant already low; busy is high for cycles k+1..k+L+2.
- Back-to-back service: next grant at k+L+4 (DONE → IDLE → grant).
- The minimum period per grant is 3 cycles when L = 0.
- All outputs are registered; no combinational path from req/len to outputs.

## Structure
- Package timer_arb_pkg:
  - state typedef {IDLE, RUN, DONE}.
  - Default N and R constants.
  - Round-robin pick function (req, ptr) → index.
- Sub-module interval_counter:
  - N-bit up counter with synchronous clear, enable, and a terminal-match output against a loaded target.
  - The arbiter FSM drives its clear and enable and owns the target register.

## Test plan
- Single request: reset, then req=0001, len0=3 → grant=0001 for 4 cycles with count 0,1,2,3; done=0001 for 1 cycle; busy high for 5 cycles; outputs 0 afterwards.
- Round-robin fairness: req=1111, all len=0, held → grant sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles, each followed by the matching done pulse.
- Abort: req=0100, len2=10; drop req[2] when count=4 → grant clears next cycle; no done; count=0; next grant goes to index 3 if requested.
- Full range and sample-once: N=8, len1=255 → grant held 256 cycles, count reaches 255 without wrap, done=0010. Changing len1 mid-run to 5 must not shorten the interval.
- Reset mid-operation: reset asserted during RUN at count=7 → next cycle grant=0, done=0, busy=0, count=0. After release with req=0011, the winner is index 0 (ptr reset).
